mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit_if.sv | 30 +++
 rtl/mem_access_unit.sv | 156 +++++++++++++++
 tb/tb_mem_access_unit.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
// Request/response and data-memory bus of the memory access unit.
// The unit takes the slave view; the pipeline/memory side takes the master view.
interface mem_access_unit_if #(
    parameter int DM_AW = 10
);
    logic             req_valid;
    logic             req_ready;
    logic             req_we;
    logic [1:0]       req_size;
    logic             req_sext;
    logic [31:0]      req_addr;
    logic [31:0]      req_wdata;
    logic             resp_valid;
    logic [31:0]      resp_rdata;
    logic             resp_err;
    logic [DM_AW-1:0] dm_addr;
    logic [31:0]      dm_din;
    logic             dm_we;
    logic [31:0]      dm_dout;

    modport slave (
        input  req_valid, req_we, req_size, req_sext, req_addr, req_wdata, dm_dout,
        output req_ready, resp_valid, resp_rdata, resp_err, dm_addr, dm_din, dm_we
    );

    modport master (
        output req_valid, req_we, req_size, req_sext, req_addr, req_wdata, dm_dout,
        input  req_ready, resp_valid, resp_rdata, resp_err, dm_addr, dm_din, dm_we
    );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store unit between a pipeline and a single-port word memory.
// Sub-word stores are read-modify-write; one request in flight at a time.
module mau_lane (
    input  logic       sel,
    input  logic [7:0] old_byte,
    input  logic [7:0] new_byte,
    output logic [7:0] merged
);
    assign merged = sel ? new_byte : old_byte;
endmodule

module mem_access_unit #(
    parameter int DM_AW = 10
) (
    input  logic             clk,
    input  logic             rstn,
    mem_access_unit_if.slave bus
);
    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_X = 2'b11;

    typedef enum logic [2:0] {IDLE, LOAD, MERGE, WRITE, RESP} state_t;

    // Only the low halfword of store data is kept; word stores go straight to dm_din.
    typedef struct packed {
        logic        we;
        logic [1:0]  size;
        logic        sext;
        logic [1:0]  off;
        logic        err;
        logic [15:0] wdata;
    } req_t;

    state_t           state_q, state_d;
    req_t             req_q, req_d;
    logic [DM_AW-1:0] dm_addr_q, dm_addr_d;
    logic [31:0]      dm_din_q, dm_din_d;
    logic [31:0]      rdata_q, rdata_d;

    logic             accept;
    logic             in_err;
    logic [31:0]      lane_sh;
    logic [31:0]      load_val;
    logic [3:0]       lane_sel;
    logic [3:0][7:0]  lane_new;
    logic [3:0][7:0]  lane_mrg;

    assign accept = bus.req_valid && bus.req_ready;
    assign in_err = (bus.req_size == SZ_X) ||
                    (bus.req_size == SZ_H && bus.req_addr[0]) ||
                    (bus.req_size == SZ_W && bus.req_addr[1:0] != 2'b00);

    // Load extraction: shift the addressed lane down to bit 0, then extend.
    always_comb begin
        lane_sh  = bus.dm_dout >> {req_q.off, 3'b000};
        load_val = bus.dm_dout;
        case (req_q.size)
            SZ_B:    load_val = {{24{req_q.sext & lane_sh[7]}}, lane_sh[7:0]};
            SZ_H:    load_val = {{16{req_q.sext & lane_sh[15]}}, lane_sh[15:0]};
            default: load_val = bus.dm_dout;
        endcase
    end

    // Byte-lane merge for sub-word stores; halfwords feed wdata[15:8] into odd lanes.
    always_comb begin
        lane_sel = '0;
        lane_new = '0;
        for (int i = 0; i < 4; i++) begin
            lane_sel[i] = (req_q.size == SZ_B) ? (req_q.off == 2'(i)) : (req_q.off[1] == i[1]);
            lane_new[i] = (req_q.size == SZ_H && i[0]) ? req_q.wdata[15:8] : req_q.wdata[7:0];
        end
    end

    for (genvar i = 0; i < 4; i++) begin : g_lane
        mau_lane u_lane (
            .sel      (lane_sel[i]),
            .old_byte (bus.dm_dout[8*i +: 8]),
            .new_byte (lane_new[i]),
            .merged   (lane_mrg[i])
        );
    end

    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        dm_addr_d = dm_addr_q;
        dm_din_d  = dm_din_q;
        rdata_d   = rdata_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    req_d.we    = bus.req_we;
                    req_d.size  = bus.req_size;
                    req_d.sext  = bus.req_sext;
                    req_d.off   = bus.req_addr[1:0];
                    req_d.err   = in_err;
                    req_d.wdata = bus.req_wdata[15:0];
                    dm_addr_d   = bus.req_addr[DM_AW+1:2];
                    if (in_err) begin
                        state_d = RESP;
                    end else if (!bus.req_we) begin
                        state_d = LOAD;
                    end else if (bus.req_size == SZ_W) begin
                        state_d  = WRITE;
                        dm_din_d = bus.req_wdata;
                    end else begin
                        state_d = MERGE;
                    end
                end
            end
            LOAD: begin
                rdata_d = load_val;
                state_d = RESP;
            end
            MERGE: begin
                dm_din_d = lane_mrg;
                state_d  = WRITE;
            end
            WRITE:   state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            req_q     <= '0;
            dm_addr_q <= '0;
            dm_din_q  <= '0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            dm_addr_q <= dm_addr_d;
            dm_din_q  <= dm_din_d;
            rdata_q   <= rdata_d;
        end
    end

    // The async reset clears state_q at once, so dm_we drops without waiting for clk.
    assign bus.req_ready  = rstn && (state_q == IDLE);
    assign bus.resp_valid = (state_q == RESP);
    assign bus.resp_err   = (state_q == RESP) && req_q.err;
    assign bus.resp_rdata = ((state_q == RESP) && (req_q.we || req_q.err)) ? 32'd0 : rdata_q;
    assign bus.dm_addr    = dm_addr_q;
    assign bus.dm_din     = dm_din_q;
    assign bus.dm_we      = (state_q == WRITE);

    if (DM_AW < 30) begin : g_unused
        logic unused_addr_hi;
        assign unused_addr_hi = ^bus.req_addr[31:DM_AW+2];
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized bench for mem_access_unit with a byte-mask reference model
// of memory contents, load results, error decode and latency.
module tb_mem_access_unit;
    localparam int AW = 10;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    mem_access_unit_if #(.DM_AW(AW)) bus ();
    mem_access_unit #(.DM_AW(AW)) dut (.clk(clk), .rstn(rstn), .bus(bus));

    // Memory model; preloaded through a side port while reset is held.
    logic [31:0] mem [1024];
    logic        ld_en  = 1'b0;
    logic [4:0]  ld_idx = '0;
    logic [31:0] ld_val = '0;
    assign bus.dm_dout = mem[bus.dm_addr];
    always @(posedge clk) begin
        if (ld_en) mem[{5'd0, ld_idx}] <= ld_val;
        else if (bus.dm_we) mem[bus.dm_addr] <= bus.dm_din;
    end

    logic [31:0] ref_mem [32];
    logic [31:0] last_load = '0;
    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h want 0x%08h", tag, act, exp);
    endtask

    function automatic logic model_err(input logic [1:0] sz, input logic [31:0] a);
        return (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
    endfunction

    function automatic logic [31:0] width_mask(input logic [1:0] sz);
        return (sz == 2'd0) ? 32'h0000_00FF : (sz == 2'd1) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] w, input logic [1:0] sz,
                                               input logic sx, input logic [31:0] a);
        logic [31:0] v, m;
        logic        sb;
        m  = width_mask(sz);
        v  = (w >> (8 * int'(a[1:0]))) & m;
        sb = (sz == 2'd0) ? v[7] : (sz == 2'd1) ? v[15] : 1'b0;
        if (sx && sb) v = v | ~m;
        return v;
    endfunction

    function automatic logic [31:0] model_store(input logic [31:0] w, input logic [1:0] sz,
                                                input logic [31:0] a, input logic [31:0] wd);
        logic [31:0] m;
        m = width_mask(sz) << (8 * int'(a[1:0]));
        return (w & ~m) | ((wd << (8 * int'(a[1:0]))) & m);
    endfunction

    task automatic do_req(input logic we, input logic [1:0] sz, input logic sx,
                          input logic [31:0] a, input logic [31:0] wd, output logic [31:0] rd);
        logic        err;
        logic [31:0] exp_rd, exp_new;
        int          widx, exp_lat, lat, we_cnt, k;
        widx    = int'(a[6:2]);
        err     = model_err(sz, a);
        exp_new = model_store(ref_mem[widx], sz, a, wd);
        exp_rd  = (err || we) ? 32'd0 : model_load(ref_mem[widx], sz, sx, a);
        exp_lat = err ? 0 : (!we || sz == 2'd2) ? 1 : 2;
        @(negedge clk);
        bus.req_we = we; bus.req_size = sz; bus.req_sext = sx;
        bus.req_addr = a; bus.req_wdata = wd; bus.req_valid = 1'b1;
        k = 0;
        while (!bus.req_ready && k < 20) begin @(negedge clk); k++; end
        if (!bus.req_ready) chk("rdy_timeout", 32'(bus.req_ready), 32'd1);
        @(posedge clk);
        #1;
        // Fields are don't-care once accepted; scramble them.
        bus.req_valid = 1'b0; bus.req_we = 1'($urandom()); bus.req_size = 2'($urandom());
        bus.req_addr = $urandom(); bus.req_wdata = $urandom(); bus.req_sext = 1'($urandom());
        lat = -1; we_cnt = 0; rd = '0;
        for (int c = 0; c < 6 && lat < 0; c++) begin
            @(negedge clk);
            if (bus.dm_we) begin
                we_cnt++;
                chk("dm_addr", 32'(bus.dm_addr), 32'(widx));
                chk("dm_din", bus.dm_din, exp_new);
            end
            if (bus.resp_valid) begin
                lat = c;
                rd  = bus.resp_rdata;
                chk("rdata", bus.resp_rdata, exp_rd);
                chk("err", 32'(bus.resp_err), 32'(err));
            end
        end
        chk("latency", 32'(lat), 32'(exp_lat));
        chk("we_cnt", 32'(we_cnt), 32'(we && !err));
        if (we && !err) ref_mem[widx] = exp_new;
        if (!we && !err) last_load = exp_rd;
        @(negedge clk);
        chk("pulse", 32'(bus.resp_valid), 32'd0);
        chk("rd_hold", bus.resp_rdata, last_load);
        chk("mem", mem[widx], ref_mem[widx]);
    endtask

    task automatic rst_in_write();
        int saw;
        @(negedge clk);
        bus.req_we = 1'b1; bus.req_size = 2'd0; bus.req_sext = 1'b0;
        bus.req_addr = 32'h0000_001D; bus.req_wdata = 32'h0000_00C3; bus.req_valid = 1'b1;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_we_pre", 32'(bus.dm_we), 32'd1);
        #2 rstn = 1'b0;
        #1;
        chk("rst_we_drop", 32'(bus.dm_we), 32'd0);
        chk("rst_rdy_low", 32'(bus.req_ready), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        last_load = '0;
        saw = 0;
        for (int c = 0; c < 4; c++) begin
            if (bus.resp_valid) saw = 1;
            @(negedge clk);
        end
        chk("rst_noresp", 32'(saw), 32'd0);
        chk("rst_rdy_high", 32'(bus.req_ready), 32'd1);
        chk("rst_mem", mem[7], ref_mem[7]);
        chk("rst_rdata", bus.resp_rdata, 32'd0);
    endtask

    task automatic b2b();
        logic [31:0] addrs [4];
        int          acc_cyc [4];
        int          nacc, nresp, cyc;
        logic        rdy;
        addrs = '{32'hABC0_0020, 32'h0000_0044, 32'h5550_0008, 32'h0000_007C};
        nacc = 0; nresp = 0; cyc = 0;
        @(negedge clk);
        bus.req_we = 1'b0; bus.req_size = 2'd2; bus.req_sext = 1'b0;
        bus.req_addr = addrs[0]; bus.req_valid = 1'b1;
        while ((nacc < 4 || nresp < 4) && cyc < 40) begin
            rdy = bus.req_ready;
            @(posedge clk);
            if (rdy && nacc < 4) begin
                acc_cyc[nacc] = cyc;
                nacc++;
                #1;
                if (nacc < 4) bus.req_addr = addrs[nacc];
                else bus.req_valid = 1'b0;
            end
            @(negedge clk);
            cyc++;
            if (bus.resp_valid) begin
                if (nresp < 4) chk("b2b_rdata", bus.resp_rdata, ref_mem[int'(addrs[nresp][6:2])]);
                nresp++;
            end
        end
        bus.req_valid = 1'b0;
        chk("b2b_nacc", 32'(nacc), 32'd4);
        chk("b2b_nresp", 32'(nresp), 32'd4);
        for (int i = 1; i < 4; i++) chk("b2b_gap", 32'(acc_cyc[i] - acc_cyc[i-1]), 32'd3);
        last_load = ref_mem[int'(addrs[3][6:2])];
    endtask

    initial begin
        logic [31:0] rd, r, a;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'd0;
        bus.req_sext = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
        for (int i = 0; i < 32; i++) begin
            ld_en  = 1'b1;
            ld_idx = 5'(i);
            ld_val = (i == 4) ? 32'h8899_AABB : $urandom();
            ref_mem[i] = ld_val;
            @(posedge clk);
            #1;
        end
        ld_en = 1'b0;
        chk("rst_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_rdata0", bus.resp_rdata, 32'd0);
        chk("rst_err", 32'(bus.resp_err), 32'd0);
        chk("rst_dm_addr", 32'(bus.dm_addr), 32'd0);
        chk("rst_dm_din", bus.dm_din, 32'd0);
        chk("rst_dm_we", 32'(bus.dm_we), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        chk("ready_up", 32'(bus.req_ready), 32'd1);

        do_req(1'b0, 2'd0, 1'b1, 32'h0000_0012, 32'h0, rd);
        chk("lb_sext", rd, 32'hFFFF_FF99);
        do_req(1'b0, 2'd0, 1'b0, 32'h0000_0012, 32'h0, rd);
        chk("lb_zext", rd, 32'h0000_0099);
        do_req(1'b1, 2'd1, 1'b0, 32'h0000_0012, 32'h0000_1234, rd);
        chk("sh_merge", mem[4], 32'h1234_AABB);
        do_req(1'b1, 2'd2, 1'b0, 32'h0000_0000, 32'hDEAD_BEEF, rd);
        do_req(1'b0, 2'd2, 1'b0, 32'h0000_0000, 32'h0, rd);
        chk("sw_lw", rd, 32'hDEAD_BEEF);
        do_req(1'b0, 2'd2, 1'b0, 32'h0000_0006, 32'h0, rd);
        do_req(1'b1, 2'd1, 1'b0, 32'h0000_0003, 32'h0000_5555, rd);
        do_req(1'b1, 2'd3, 1'b0, 32'h0000_0008, 32'h1111_2222, rd);

        rst_in_write();
        b2b();

        repeat (60) begin
            r = $urandom();
            a = $urandom();
            a[11:7] = 5'd0;
            if (r[6:4] != 3'd0) begin
                if (r[2:1] == 2'd1) a[0] = 1'b0;
                if (r[2:1] == 2'd2) a[1:0] = 2'd0;
            end
            do_req(r[0], r[2:1], r[3], a, $urandom(), rd);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end
endmodule
